// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the five-stage in-order core.
// It handles load-use stalls with a configurable bubble depth, flush sequencing
// for taken branches, and the data-memory freeze. It also keeps two saturating
// performance counters. All control outputs are combinational from the inputs
// and the current state. Only state, cnt and the counters are registered.
module hazard_ctrl_unit #(
  parameter int REG_AW             = 5,
  parameter int LOAD_STALL_CYCLES  = 1,
  parameter int FLUSH_CYCLES       = 1,
  parameter int ZERO_REG_HARDWIRED = 1,
  parameter int PERF_W             = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_ex_mem_read,
  input  logic [REG_AW-1:0] id_ex_write_reg,
  input  logic [REG_AW-1:0] if_id_rs1,
  input  logic [REG_AW-1:0] if_id_rs2,
  input  logic              if_id_use_rs1,
  input  logic              if_id_use_rs2,
  input  logic              branch_taken,
  input  logic              mem_busy,
  input  logic              perf_clr,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic              flush,
  output logic              pipe_hold,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] hazard_events
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2
  } state_t;

  // Reload values for cnt: the first cycle of a sequence is spent in RUN,
  // so the counter only needs to cover the remaining cycles.
  localparam logic [3:0]        LS_RELOAD = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0]        FL_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [PERF_W-1:0] PERF_MAX  = '1;
  localparam logic [PERF_W-1:0] PERF_ONE  = PERF_W'(1);

  state_t     state;
  logic [3:0] cnt;

  logic hit_rs1;
  logic hit_rs2;
  logic wr_is_zero;
  logic hz;
  logic hz_event;

  assign hit_rs1    = if_id_use_rs1 && (if_id_rs1 == id_ex_write_reg);
  assign hit_rs2    = if_id_use_rs2 && (if_id_rs2 == id_ex_write_reg);
  assign wr_is_zero = (id_ex_write_reg == '0);
  assign hz         = id_ex_mem_read && (hit_rs1 || hit_rs2) &&
                      !((ZERO_REG_HARDWIRED != 0) && wr_is_zero);

  // Control outputs. Priority is the memory freeze, then the branch flush,
  // then the current state or a newly detected hazard.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    flush        = 1'b0;
    pipe_hold    = 1'b0;
    hz_event     = 1'b0;
    if (mem_busy) begin
      pipe_hold   = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (branch_taken) begin
      flush        = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      case (state)
        FLUSH: begin
          flush        = 1'b1;
          id_ex_bubble = 1'b1;
        end
        LOAD_STALL: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
        default: begin
          if (hz) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            hz_event     = 1'b1;
          end
        end
      endcase
    end
  end

  // Sequencer. mem_busy freezes it. A taken branch aborts any stall and may
  // start a flush. Stall and flush sequences count down cnt back to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else if (mem_busy) begin
      state <= state;
      cnt   <= cnt;
    end else if (branch_taken) begin
      if (FLUSH_CYCLES > 1) begin
        state <= FLUSH;
        cnt   <= FL_RELOAD;
      end else begin
        state <= RUN;
        cnt   <= 4'd0;
      end
    end else begin
      case (state)
        LOAD_STALL, FLUSH: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= RUN;
        end
        default: begin
          if (hz && (LOAD_STALL_CYCLES > 1)) begin
            state <= LOAD_STALL;
            cnt   <= LS_RELOAD;
          end
        end
      endcase
    end
  end

  // Saturating performance counters. A clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles  <= '0;
      hazard_events <= '0;
    end else if (perf_clr) begin
      stall_cycles  <= '0;
      hazard_events <= '0;
    end else begin
      if (!pc_write && (stall_cycles != PERF_MAX))
        stall_cycles <= stall_cycles + PERF_ONE;
      if (hz_event && (hazard_events != PERF_MAX))
        hazard_events <= hazard_events + PERF_ONE;
    end
  end

endmodule
